// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock supervisor: sequences the PLL reset, qualifies a synchronized lock,
// releases the system reset after a stable window, and retries or faults on lock trouble.
module pll_lock_supervisor #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                               refclk,
  input  logic                               rst,
  input  logic                               pll_locked,
  output logic                               pll_rst,
  output logic                               sys_rst,
  output logic                               ready,
  output logic                               fault,
  input  logic                               relock_req,
  output logic                               relock_ack,
  input  logic                               clear_fault,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt,
  output logic [15:0]                        lock_loss_cnt
);

  localparam int RW      = $clog2(MAX_RETRIES + 1);
  localparam int CNT_MAX = (RST_CYCLES > LOCK_TIMEOUT)
                         ? ((RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES)
                         : ((LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES);
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SAT     = CW'(CNT_MAX - 1);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CW-1:0]          r_cnt;
  logic [CW-1:0]          w_cnt_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_locked_s;

  logic                   r_pll_rst;
  logic                   r_sys_rst;
  logic                   r_ready;
  logic                   r_fault;
  logic                   r_ack;
  logic [RW-1:0]          r_retry;
  logic [15:0]            r_loss;

  logic                   w_pll_rst_nxt;
  logic                   w_sys_rst_nxt;
  logic                   w_ready_nxt;
  logic                   w_fault_nxt;
  logic                   w_ack_nxt;
  logic [RW-1:0]          w_retry_nxt;
  logic [RW-1:0]          w_retry_inc;
  logic [15:0]            w_loss_nxt;

  // pll_locked is asynchronous to refclk; only the last stage feeds the control logic.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign w_locked_s  = r_sync[SYNC_STAGES-1];
  assign w_retry_inc = r_retry + 1'b1;

  // NOTE: every combinational output gets a default first so no path leaves a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_retry_nxt = r_retry;
    w_loss_nxt  = r_loss;
    w_ack_nxt   = 1'b0;
    case (r_state)
      S_PLL_RST: begin
        if (r_cnt == RST_LAST) w_state_nxt = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (w_locked_s) begin
          w_state_nxt = S_STABLE;
        end else if (r_cnt == LOCK_LAST) begin
          w_retry_nxt = w_retry_inc;
          w_state_nxt = (w_retry_inc == RETRY_LIMIT) ? S_FAULT : S_PLL_RST;
        end
      end
      S_STABLE: begin
        // A drop wins over a window that would complete on the same edge.
        if (!w_locked_s) begin
          w_state_nxt = S_WAIT_LOCK;
        end else if (r_cnt == STABLE_LAST) begin
          w_state_nxt = S_RUN;
          w_retry_nxt = '0;
        end
      end
      S_RUN: begin
        if (!w_locked_s || relock_req) begin
          w_state_nxt = S_PLL_RST;
          if (!w_locked_s && (r_loss != 16'hFFFF)) w_loss_nxt = r_loss + 16'd1;
          if (relock_req) w_ack_nxt = 1'b1;
        end
      end
      S_FAULT: begin
        if (clear_fault) begin
          w_state_nxt = S_PLL_RST;
          w_retry_nxt = '0;
        end
      end
      default: w_state_nxt = S_PLL_RST;
    endcase
  end

  // Shared counter restarts on every transition and parks at its top value otherwise.
  always_comb begin
    if (w_state_nxt != r_state) begin
      w_cnt_nxt = '0;
    end else if (r_cnt == CNT_SAT) begin
      w_cnt_nxt = r_cnt;
    end else begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  // Outputs are decoded from the next state so they register on the same edge as the state.
  always_comb begin
    w_pll_rst_nxt = 1'b1;
    w_sys_rst_nxt = 1'b1;
    w_ready_nxt   = 1'b0;
    w_fault_nxt   = 1'b0;
    case (w_state_nxt)
      S_WAIT_LOCK, S_STABLE: begin
        w_pll_rst_nxt = 1'b0;
      end
      S_RUN: begin
        w_pll_rst_nxt = 1'b0;
        w_sys_rst_nxt = 1'b0;
        w_ready_nxt   = 1'b1;
      end
      S_FAULT: begin
        w_fault_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_state   <= S_PLL_RST;
      r_cnt     <= '0;
      r_pll_rst <= 1'b1;
      r_sys_rst <= 1'b1;
      r_ready   <= 1'b0;
      r_fault   <= 1'b0;
      r_ack     <= 1'b0;
      r_retry   <= '0;
      r_loss    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pll_rst <= w_pll_rst_nxt;
      r_sys_rst <= w_sys_rst_nxt;
      r_ready   <= w_ready_nxt;
      r_fault   <= w_fault_nxt;
      r_ack     <= w_ack_nxt;
      r_retry   <= w_retry_nxt;
      r_loss    <= w_loss_nxt;
    end
  end

  assign pll_rst       = r_pll_rst;
  assign sys_rst       = r_sys_rst;
  assign ready         = r_ready;
  assign fault         = r_fault;
  assign relock_ack    = r_ack;
  assign retry_cnt     = r_retry;
  assign lock_loss_cnt = r_loss;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: directed scenarios plus randomized lock
// behaviour, all compared every cycle against a phase/elapsed-time reference model.
module tb_pll_lock_supervisor;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 20;
  localparam int STABLE_CYCLES = 8;
  localparam int MAX_RETRIES   = 2;
  localparam int SYNC_STAGES   = 2;
  localparam int RW            = $clog2(MAX_RETRIES + 1);

  logic          refclk      = 1'b0;
  logic          rst         = 1'b0;
  logic          pll_locked  = 1'b0;
  logic          relock_req  = 1'b0;
  logic          clear_fault = 1'b0;
  logic          pll_rst;
  logic          sys_rst;
  logic          ready;
  logic          fault;
  logic          relock_ack;
  logic [RW-1:0] retry_cnt;
  logic [15:0]   lock_loss_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  pll_lock_supervisor #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .STABLE_CYCLES(STABLE_CYCLES),
    .MAX_RETRIES  (MAX_RETRIES),
    .SYNC_STAGES  (SYNC_STAGES)
  ) dut (
    .refclk       (refclk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .pll_rst      (pll_rst),
    .sys_rst      (sys_rst),
    .ready        (ready),
    .fault        (fault),
    .relock_req   (relock_req),
    .relock_ack   (relock_ack),
    .clear_fault  (clear_fault),
    .retry_cnt    (retry_cnt),
    .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 refclk = ~refclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: which phase the supervisor is in and how long it has been there.
  localparam int PH_RST   = 0;
  localparam int PH_WAIT  = 1;
  localparam int PH_STAB  = 2;
  localparam int PH_RUN   = 3;
  localparam int PH_FAULT = 4;

  int ph;
  int age;
  int m_retry;
  int m_loss;
  bit m_ack;
  bit lk_q[$];

  always @(posedge refclk or posedge rst) begin
    if (rst) begin
      ph      = PH_RST;
      age     = 0;
      m_retry = 0;
      m_loss  = 0;
      m_ack   = 1'b0;
      lk_q.delete();
      for (int i = 0; i < SYNC_STAGES; i++) lk_q.push_back(1'b0);
    end else begin
      bit ls;
      int nph;
      ls    = lk_q[SYNC_STAGES-1];
      nph   = ph;
      m_ack = 1'b0;
      case (ph)
        PH_RST:  if (age + 1 >= RST_CYCLES) nph = PH_WAIT;
        PH_WAIT: begin
          if (ls) nph = PH_STAB;
          else if (age + 1 >= LOCK_TIMEOUT) begin
            m_retry = m_retry + 1;
            nph = (m_retry >= MAX_RETRIES) ? PH_FAULT : PH_RST;
          end
        end
        PH_STAB: begin
          if (!ls) nph = PH_WAIT;
          else if (age + 1 >= STABLE_CYCLES) begin
            nph = PH_RUN;
            m_retry = 0;
          end
        end
        PH_RUN: begin
          if (!ls || relock_req) begin
            if (!ls && m_loss < 65535) m_loss = m_loss + 1;
            m_ack = relock_req;
            nph = PH_RST;
          end
        end
        default: begin
          if (clear_fault) begin
            m_retry = 0;
            nph = PH_RST;
          end
        end
      endcase
      age = (nph == ph) ? age + 1 : 0;
      ph  = nph;
      lk_q.push_front(pll_locked);
      void'(lk_q.pop_back());
    end
  end

  // Expected {pll_rst, sys_rst, ready, fault, relock_ack}
  function automatic logic [4:0] exp_ctl();
    case (ph)
      PH_RST:           return {4'b1100, m_ack};
      PH_WAIT, PH_STAB: return 5'b01000;
      PH_RUN:           return 5'b00100;
      default:          return 5'b11010;
    endcase
  endfunction

  always @(negedge refclk) begin
    if (chk_en) begin
      check("ctl", 32'({pll_rst, sys_rst, ready, fault, relock_ack}), 32'(exp_ctl()));
      check("retry_cnt", 32'(retry_cnt), 32'(m_retry));
      check("lock_loss_cnt", 32'(lock_loss_cnt), 32'(m_loss));
    end
  end

  function automatic logic sig(input int sel);
    case (sel)
      0:       return pll_rst;
      1:       return ready;
      2:       return fault;
      3:       return relock_ack;
      default: return sys_rst;
    endcase
  endfunction

  // Called at a negedge: number of consecutive negedges the signal holds val.
  task automatic count_level(input int sel, input logic val, output int n);
    n = 0;
    while (sig(sel) === val && n < 200) begin
      n++;
      @(negedge refclk);
    end
  endtask

  // Number of rising edges until the signal shows val (sampled 1 time unit after the edge).
  task automatic wait_sig(input string tag, input int sel, input logic val, output int n);
    n = 0;
    do begin
      @(posedge refclk);
      #1;
      n++;
    end while (sig(sel) !== val && n < 300);
    check(tag, 32'(sig(sel)), 32'(val));
  endtask

  task automatic wait_phase(input int p);
    int k;
    k = 0;
    while (ph != p && k < 300) begin
      @(negedge refclk);
      k++;
    end
    check("reach_phase", ph, p);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    int n;
    int acks;

    // Reset values, taken before any clock edge
    #2 rst = 1'b1;
    #1;
    check("rst_ctl", 32'({pll_rst, sys_rst, ready, fault, relock_ack}), 32'(5'b11000));
    check("rst_retry", 32'(retry_cnt), 0);
    check("rst_loss", 32'(lock_loss_cnt), 0);
    chk_en = 1'b1;
    repeat (2) @(negedge refclk);
    rst = 1'b0;

    // Normal lock
    count_level(0, 1'b1, n);
    check("t1_pll_rst_pulse", n, RST_CYCLES);
    repeat (2) @(negedge refclk);
    pll_locked = 1'b1;
    @(posedge refclk);
    wait_sig("t1_ready", 1, 1'b1, n);
    check("t1_lock_to_ready", n, SYNC_STAGES + STABLE_CYCLES);
    check("t1_sys_rst", 32'(sys_rst), 0);
    check("t1_retry", 32'(retry_cnt), 0);

    // Lock loss in RUN
    @(negedge refclk);
    pll_locked = 1'b0;
    wait_sig("t4_ready_fall", 1, 1'b0, n);
    check("t4_loss_latency", n, SYNC_STAGES + 1);
    check("t4_loss_cnt", 32'(lock_loss_cnt), 1);
    check("t4_pll_rst", 32'(pll_rst), 1);

    // Retry then fault, lock held low
    @(negedge refclk);
    count_level(0, 1'b1, n);
    check("t2_pulse1", n, RST_CYCLES);
    count_level(0, 1'b0, n);
    check("t2_wait1", n, LOCK_TIMEOUT);
    check("t2_retry1", 32'(retry_cnt), 1);
    count_level(0, 1'b1, n);
    check("t2_pulse2", n, RST_CYCLES);
    count_level(0, 1'b0, n);
    check("t2_wait2", n, LOCK_TIMEOUT);
    check("t2_retry2", 32'(retry_cnt), 2);
    check("t2_fault", 32'(fault), 1);
    repeat (3) @(negedge refclk);
    check("t2_fault_hold", 32'({fault, pll_rst}), 32'(2'b11));
    clear_fault = 1'b1;
    @(negedge refclk);
    clear_fault = 1'b0;
    check("t2_fault_clr", 32'(fault), 0);
    check("t2_retry_clr", 32'(retry_cnt), 0);
    count_level(0, 1'b1, n);
    check("t2_pulse_after_clear", n, RST_CYCLES);

    // One more timeout so the glitch test has a nonzero retry count to preserve
    count_level(0, 1'b0, n);
    check("t3_wait", n, LOCK_TIMEOUT);
    count_level(0, 1'b1, n);
    check("t3_pulse", n, RST_CYCLES);

    // Glitch in STABLE
    pll_locked = 1'b1;
    wait_phase(PH_STAB);
    repeat (5) @(negedge refclk);
    pll_locked = 1'b0;
    @(negedge refclk);
    pll_locked = 1'b1;
    check("t3_retry_kept", 32'(retry_cnt), 1);
    check("t3_not_ready", 32'(ready), 0);
    @(posedge refclk);
    wait_sig("t3_ready", 1, 1'b1, n);
    check("t3_fresh_window", n, SYNC_STAGES + STABLE_CYCLES);
    check("t3_retry_clr", 32'(retry_cnt), 0);

    // Relock request coinciding with a lock loss seen by the control logic
    @(negedge refclk);
    pll_locked = 1'b0;
    repeat (2) @(negedge refclk);
    relock_req = 1'b1;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge refclk);
      if (relock_ack === 1'b1) acks++;
      if (i == 2) relock_req = 1'b0;
    end
    check("t5_ack_count", acks, 1);
    check("t5_loss_cnt", 32'(lock_loss_cnt), 2);

    // Request during WAIT_LOCK is ignored
    check("t5_in_wait", 32'({pll_rst, sys_rst}), 32'(2'b01));
    relock_req = 1'b1;
    acks = 0;
    repeat (10) begin
      @(negedge refclk);
      if (relock_ack === 1'b1) acks++;
    end
    relock_req = 1'b0;
    check("t5_wait_ack_count", acks, 0);

    // Asynchronous reset mid-STABLE
    pll_locked = 1'b1;
    wait_phase(PH_STAB);
    repeat (3) @(negedge refclk);
    #2 rst = 1'b1;
    #1;
    check("t6_ctl", 32'({pll_rst, sys_rst, ready, fault, relock_ack}), 32'(5'b11000));
    check("t6_retry", 32'(retry_cnt), 0);
    check("t6_loss", 32'(lock_loss_cnt), 0);
    @(negedge refclk);
    rst = 1'b0;

    // Randomized lock behaviour, requests and clears
    for (int seg = 0; seg < 200; seg++) begin
      int len;
      bit lv;
      len = $urandom_range(1, 40);
      lv  = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 39) == 0) begin
        @(negedge refclk);
        #2 rst = 1'b1;
        @(negedge refclk);
        rst = 1'b0;
      end
      for (int c = 0; c < len; c++) begin
        @(negedge refclk);
        pll_locked  = lv;
        relock_req  = ($urandom_range(0, 24) == 0);
        clear_fault = ($urandom_range(0, 7) == 0);
      end
    end
    relock_req  = 1'b0;
    clear_fault = 1'b0;
    @(negedge refclk);
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
